// File: rtl/button_debouncer_n.sv
// button_debouncer_n: N-channel button conditioner with sync, stability filter, press/release strobes, hold-to-repeat
// clk: single clock | rst_n: synchronous, active low | in: raw asynchronous levels (1 = pressed)
// repeat_en: per-channel auto-repeat enable | level: debounced level
// press / released: one-cycle strobes on accepted 0->1 / 1->0 | pulse: press or repeat strobe
module button_debouncer_n #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] pulse
);
  localparam int SW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_t;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, lvl, lvl_nxt, accept, strobe, prs, rls, pls;
    logic [SW-1:0]          stab_cnt, stab_nxt;
    logic [RW-1:0]          rpt_cnt, rpt_nxt;
    rpt_t                   state, state_nxt;
    assign s        = sync[SYNC_STAGES-1];
    assign accept   = (s != lvl) && (stab_cnt == SW'(STABLE_CYCLES - 1));
    assign lvl_nxt  = accept ? s : lvl;
    assign stab_nxt = ((s == lvl) || accept) ? '0 : stab_cnt + 1'b1;
    // Repeat decisions look at the level this edge will produce, so a falling
    // level and a repeat strobe can never coincide.
    always_comb begin
      state_nxt = state;
      rpt_nxt   = rpt_cnt + 1'b1;
      strobe    = 1'b0;
      if (!repeat_en[c] || !lvl_nxt) begin
        state_nxt = IDLE;
        rpt_nxt   = '0;
      end else begin
        case (state)
          IDLE: begin
            state_nxt = DELAY;
            rpt_nxt   = '0;
          end
          DELAY: if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
            strobe    = 1'b1;
            state_nxt = REPEAT;
            rpt_nxt   = '0;
          end
          REPEAT: if (rpt_cnt == RW'(REPEAT_PERIOD - 1)) begin
            strobe  = 1'b1;
            rpt_nxt = '0;
          end
          default: begin
            state_nxt = IDLE;
            rpt_nxt   = '0;
          end
        endcase
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync     <= '0;
        stab_cnt <= '0;
        lvl      <= 1'b0;
        state    <= IDLE;
        rpt_cnt  <= '0;
        prs      <= 1'b0;
        rls      <= 1'b0;
        pls      <= 1'b0;
      end else begin
        sync     <= {sync[SYNC_STAGES-2:0], in[c]};
        stab_cnt <= stab_nxt;
        lvl      <= lvl_nxt;
        state    <= state_nxt;
        rpt_cnt  <= rpt_nxt;
        prs      <= accept & s;
        rls      <= accept & ~s;
        pls      <= (accept & s) | strobe;
      end
    end
    assign level[c]    = lvl;
    assign press[c]    = prs;
    assign released[c] = rls;
    assign pulse[c]    = pls;
  end
endmodule

// File: tb/tb_button_debouncer_n.sv
// tb_button_debouncer_n: random and directed stimulus against a window/anchor-time model of the debouncer
module tb_button_debouncer_n;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int ST = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] in = '0;
  logic [CH-1:0] repeat_en = '0;
  logic [CH-1:0] level, press, released, pulse;
  button_debouncer_n #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(ST), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .repeat_en(repeat_en),
    .level(level), .press(press), .released(released), .pulse(pulse)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;
  int rel = 0;
  // Model: inputs reach the filter SS edges late; a level is accepted once the
  // last ST filtered samples all disagree with it. Repeats are timed from the
  // edge at which the channel became armed (held and enabled).
  bit            pipe[CH][SS];
  bit            hist[CH][ST];
  bit            mlev[CH];
  bit            armed[CH];
  int            anchor[CH];
  logic [CH-1:0] elev, eprs, erel, epul;
  logic [CH-1:0] ob_lev[128], ob_prs[128], ob_rel[128], ob_pul[128];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h want %0h", name, edge_no, act, exp);
    end
  endtask
  task automatic model(input logic [CH-1:0] i, input logic [CH-1:0] e, input logic r);
    for (int c = 0; c < CH; c++) begin
      bit s, acc, nl, stb;
      int d;
      if (!r) begin
        for (int k = 0; k < SS; k++) pipe[c][k] = 1'b0;
        for (int k = 0; k < ST; k++) hist[c][k] = 1'b0;
        mlev[c] = 1'b0;
        armed[c] = 1'b0;
        elev[c] = 1'b0; eprs[c] = 1'b0; erel[c] = 1'b0; epul[c] = 1'b0;
      end else begin
        s = pipe[c][0];
        for (int k = 0; k < SS - 1; k++) pipe[c][k] = pipe[c][k+1];
        pipe[c][SS-1] = i[c];
        for (int k = 0; k < ST - 1; k++) hist[c][k] = hist[c][k+1];
        hist[c][ST-1] = s;
        acc = 1'b1;
        for (int k = 0; k < ST; k++) if (hist[c][k] == mlev[c]) acc = 1'b0;
        nl = acc ? ~mlev[c] : mlev[c];
        stb = 1'b0;
        if (!e[c] || !nl) armed[c] = 1'b0;
        else if (!armed[c]) begin
          armed[c] = 1'b1;
          anchor[c] = edge_no;
        end else begin
          d = edge_no - anchor[c];
          stb = (d >= RD) && ((d - RD) % RP == 0);
        end
        mlev[c] = nl;
        elev[c] = nl;
        eprs[c] = acc & nl;
        erel[c] = acc & ~nl;
        epul[c] = (acc & nl) | stb;
      end
    end
  endtask
  task automatic step(input logic [CH-1:0] i, input logic [CH-1:0] e, input logic r);
    in = i;
    repeat_en = e;
    rst_n = r;
    @(posedge clk);
    #1;
    edge_no++;
    rel++;
    model(i, e, r);
    check("level", 64'(level), 64'(elev));
    check("press", 64'(press), 64'(eprs));
    check("release", 64'(released), 64'(erel));
    check("pulse", 64'(pulse), 64'(epul));
    if (rel < 128) begin
      ob_lev[rel] = level; ob_prs[rel] = press; ob_rel[rel] = released; ob_pul[rel] = pulse;
    end
  endtask
  task automatic clear_log();
    rel = 0;
    for (int k = 0; k < 128; k++) begin
      ob_lev[k] = '0; ob_prs[k] = '0; ob_rel[k] = '0; ob_pul[k] = '0;
    end
  endtask
  task automatic restart();
    step('0, '0, 1'b0);
    clear_log();
  endtask
  function automatic logic [63:0] pulse_mask(input int ch);
    logic [63:0] m;
    m = '0;
    for (int k = 1; k < 64; k++) m[k] = ob_pul[k][ch];
    return m;
  endfunction
  initial begin
    logic [CH-1:0] ri, re, any1;
    restart();
    check("reset_outputs", 64'({level, press, released, pulse}), 64'd0);
    for (int k = 1; k <= 10; k++) step(4'b0001, 4'b0000, 1'b1);
    check("s1_level_e5", 64'(ob_lev[5]), 64'd0);
    check("s1_level_e6", 64'(ob_lev[6]), 64'b0001);
    check("s1_press_e6", 64'(ob_prs[6]), 64'b0001);
    check("s1_pulse_e6", 64'(ob_pul[6]), 64'b0001);
    check("s1_press_e7", 64'(ob_prs[7]), 64'd0);
    restart();
    for (int k = 1; k <= 12; k++) step((k <= 3) ? 4'b0010 : 4'b0000, 4'b0000, 1'b1);
    any1 = '0;
    for (int k = 1; k <= 12; k++) any1 |= ob_lev[k] | ob_prs[k] | ob_rel[k] | ob_pul[k];
    check("s2_glitch_ch1", 64'(any1[1]), 64'd0);
    restart();
    for (int k = 1; k <= 50; k++) step((k <= 40) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1);
    check("s3_pulse_edges", pulse_mask(2),
          (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 21) | (64'd1 << 26) |
          (64'd1 << 31) | (64'd1 << 36) | (64'd1 << 41));
    check("s3_release_e46", 64'(ob_rel[46]), 64'b0100);
    check("s3_level_e45", 64'(ob_lev[45]), 64'b0100);
    check("s3_level_e46", 64'(ob_lev[46]), 64'd0);
    restart();
    for (int k = 1; k <= 50; k++) step(4'b0100, (k >= 20 && k < 30) ? 4'b0000 : 4'b0100, 1'b1);
    check("s4_pulse_edges", pulse_mask(2),
          (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 40) | (64'd1 << 45) | (64'd1 << 50));
    restart();
    for (int k = 1; k <= 10; k++) step(4'b1000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0000, 1'b0);
    for (int k = 12; k <= 20; k++) step(4'b1000, 4'b0000, 1'b1);
    check("s5_level_held", 64'(ob_lev[10]), 64'b1000);
    check("s5_after_reset", 64'({ob_lev[11], ob_prs[11], ob_rel[11], ob_pul[11]}), 64'd0);
    check("s5_press_e16", 64'(ob_prs[16]), 64'd0);
    check("s5_press_e17", 64'(ob_prs[17]), 64'b1000);
    restart();
    for (int k = 1; k <= 10; k++) step(4'b0010, 4'b0000, 1'b1);
    clear_log();
    for (int k = 1; k <= 10; k++) step(4'b0001, 4'b0000, 1'b1);
    check("s6_press_e6", 64'(ob_prs[6]), 64'b0001);
    check("s6_release_e6", 64'(ob_rel[6]), 64'b0010);
    check("s6_level_e6", 64'(ob_lev[6]), 64'b0001);
    ri = '0;
    re = '0;
    for (int n = 0; n < 4000; n++) begin
      int rate;
      rate = ((n / 200) % 2 == 1) ? 39 : 5;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(rate) == 0) ri[c] = ~ri[c];
        if ($urandom_range(39) == 0) re[c] = ~re[c];
      end
      step(ri, re, ($urandom_range(299) != 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
